sram_sequencer: RTL and testbench
=================================

Name: sram_sequencer

Overview:
Time-multiplexes the single external SRAM (19-bit va, 8-bit vd, n_vrd/n_vwr) between three requesters: the screen fetcher, the CPU path and a DMA/loader engine (rom2ram-style). Each access runs through a fixed-length strobe sequence with registered address, data and strobes. It sits between the memory-mapping logic, which produces the requesters' physical addresses, and the SRAM pins.

Parameters:
STROBE_CYCLES, 3, clk28 cycles that n_vrd/n_vwr stay low per access (1..7).
DMA_STARVE, 8, consecutive CPU grants with dma_req pending before DMA is forced ahead of CPU (1..15).

Ports:
clk28  in  1  system clock, 28 MHz
rst  in  1  synchronous active-high reset
scr_req  in  1  screen read request, level, held until scr_ack
scr_addr  in  19  screen physical address
scr_ack  out  1  one-cycle pulse: scr_rdata valid
scr_rdata  out  8  screen read data, held until next screen ack
cpu_req  in  1  CPU request, level, held until cpu_ack
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  19  CPU physical address
cpu_wdata  in  8  CPU write data
cpu_ack  out  1  one-cycle completion pulse
cpu_rdata  out  8  CPU read data, held until next CPU read ack
dma_req, dma_we, dma_addr[18:0], dma_wdata[7:0]  in  1/1/19/8  DMA request, same rules as CPU
dma_ack  out  1  one-cycle completion pulse
dma_rdata  out  8  DMA read data
va  out  19  SRAM address (registered)
vd_in  in  8  SRAM data bus input
vd_out  out  8  SRAM write data
vd_oe  out  1  drive vd_out onto vd
n_vrd  out  1  SRAM read strobe, active low
n_vwr  out  1  SRAM write strobe, active low
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (synchronous; applies even mid-access): state IDLE, n_vrd=n_vwr=1, vd_oe=0, va=0, vd_out=0, all acks 0, all rdata 0, starvation counter 0, busy=0. An interrupted access is abandoned and is not acked.
- FSM: IDLE -> SETUP -> STROBE (STROBE_CYCLES cycles, counted by a 3-bit counter) -> RECOVER -> IDLE, or RECOVER -> SETUP when a request is pending (back-to-back operation).
- Arbitration is evaluated in IDLE and RECOVER. Priority: scr > cpu > dma. When the starvation counter equals DMA_STARVE and dma_req=1, DMA wins over CPU but never over screen.
- A grant is excluded for any requester whose ack is pulsing in the same cycle. This prevents a held request from being re-granted on its own ack edge.
- At the grant edge (entering SETUP), latch source, we, addr and wdata. va takes the latched address in SETUP and holds it through RECOVER. Later changes on requester inputs are ignored.
- Read: n_vrd=0 throughout STROBE only. Sample vd_in into the source's rdata on the last STROBE cycle. The source's ack pulses for the single RECOVER cycle.
- Write: vd_oe=1 from SETUP through RECOVER. n_vwr=0 in STROBE only, so data is stable one cycle before and after the strobe. Ack pulses in RECOVER.
- Screen requests are always reads; the screen path has no we input.
- Latency: if a request is seen in IDLE at cycle 0, ack occurs in cycle STROBE_CYCLES+2. A back-to-back access occupies STROBE_CYCLES+2 cycles per transfer.
- Starvation counter (4-bit): increments on each CPU grant while dma_req=1, saturates at DMA_STARVE, and clears on a DMA grant or when dma_req=0.
- A requester that drops its request before ack still completes its access and still receives its ack pulse.
- n_vrd and n_vwr are never both 0. vd_oe is never 1 while n_vrd=0.

Test Plan:
- Reset, then CPU read of 0x7C123 with vd_in=0xA5 and STROBE_CYCLES=3 -> va=0x7C123 from cycle 1. n_vrd low in cycles 2-4. cpu_ack pulses in cycle 5 with cpu_rdata=0xA5.
- CPU write of 0x3F to 0x40000 -> vd_oe high in cycles 1-5, n_vwr low in cycles 2-4, vd_out=0x3F. cpu_ack pulses in cycle 5. n_vrd stays high throughout.
- scr_req and cpu_req asserted in the same cycle -> screen served first with scr_ack in cycle 5. CPU then goes RECOVER->SETUP with no IDLE gap, and cpu_ack pulses in cycle 10.
- cpu_req held continuously with dma_req pending and DMA_STARVE=8 -> exactly 8 CPU grants, then one DMA grant, then the counter returns to 0 and CPU resumes.
- rst asserted during STROBE of a write -> next edge gives n_vwr=1, vd_oe=0, busy=0, and no ack pulse. A new request after rst deasserts is served normally.
- cpu_req deasserted in cycle 2 of a read -> access still completes, cpu_ack pulses in cycle 5, and no second grant occurs.

Source files
------------

// File: rtl/sram_sequencer.sv
// sram_sequencer: shares the single external SRAM between screen, CPU and DMA.
// Each access runs SETUP -> STROBE x N -> RECOVER with registered pins.
module sram_sequencer #(
  parameter int STROBE_CYCLES = 3,
  parameter int DMA_STARVE    = 8
) (
  input  logic        clk28,
  input  logic        rst,
  input  logic        scr_req,
  input  logic [18:0] scr_addr,
  output logic        scr_ack,
  output logic [7:0]  scr_rdata,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [18:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [18:0] dma_addr,
  input  logic [7:0]  dma_wdata,
  output logic        dma_ack,
  output logic [7:0]  dma_rdata,
  output logic [18:0] va,
  input  logic [7:0]  vd_in,
  output logic [7:0]  vd_out,
  output logic        vd_oe,
  output logic        n_vrd,
  output logic        n_vwr,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE, SETUP, STROBE, RECOVER
  } state_t;

  typedef enum logic [1:0] {
    SRC_SCR, SRC_CPU, SRC_DMA
  } src_t;

  localparam logic [2:0] LAST = 3'(STROBE_CYCLES - 1);
  localparam logic [3:0] SMAX = 4'(DMA_STARVE);

  state_t      state, nxt_state;
  logic [2:0]  cnt;
  src_t        src_q, nxt_src;
  logic        we_q, nxt_we;
  logic [3:0]  starve;

  logic        arb, s_ok, c_ok, d_ok, force_dma;
  logic        g_scr, g_cpu, g_dma, grant;
  src_t        g_src;
  logic        g_we;
  logic [18:0] g_addr;
  logic [7:0]  g_wdata;

  logic        o_n_vrd, o_n_vwr, o_vd_oe;
  logic        o_scr_ack, o_cpu_ack, o_dma_ack;
  logic        cap;

  assign busy = (state != IDLE);

  // Arbitration: a requester whose ack is pulsing cannot be re-granted.
  always_comb begin
    arb       = (state == IDLE) || (state == RECOVER);
    s_ok      = scr_req && !scr_ack;
    c_ok      = cpu_req && !cpu_ack;
    d_ok      = dma_req && !dma_ack;
    force_dma = (starve == SMAX) && dma_req;
    g_scr     = arb && s_ok;
    g_dma     = arb && !s_ok && d_ok && (force_dma || !c_ok);
    g_cpu     = arb && !s_ok && c_ok && !g_dma;
    grant     = g_scr || g_cpu || g_dma;
    g_src     = SRC_SCR;
    g_we      = 1'b0;
    g_addr    = scr_addr;
    g_wdata   = 8'h00;
    unique case (1'b1)
      g_scr: begin
        g_src  = SRC_SCR;
        g_addr = scr_addr;
      end
      g_cpu: begin
        g_src   = SRC_CPU;
        g_we    = cpu_we;
        g_addr  = cpu_addr;
        g_wdata = cpu_wdata;
      end
      g_dma: begin
        g_src   = SRC_DMA;
        g_we    = dma_we;
        g_addr  = dma_addr;
        g_wdata = dma_wdata;
      end
      default: ;
    endcase
  end

  // Next-state logic for the access sequence.
  always_comb begin
    nxt_state = state;
    unique case (state)
      IDLE:    if (grant) nxt_state = SETUP;
      SETUP:   nxt_state = STROBE;
      STROBE:  if (cnt == LAST) nxt_state = RECOVER;
      RECOVER: nxt_state = grant ? SETUP : IDLE;
      default: nxt_state = IDLE;
    endcase
    nxt_src = grant ? g_src : src_q;
    nxt_we  = grant ? g_we : we_q;
  end

  // State register, access latches and DMA starvation counter.
  always_ff @(posedge clk28) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 3'd0;
      src_q  <= SRC_SCR;
      we_q   <= 1'b0;
      va     <= 19'd0;
      vd_out <= 8'h00;
      starve <= 4'd0;
    end else begin
      state <= nxt_state;
      cnt   <= (state == STROBE) ? cnt + 3'd1 : 3'd0;
      if (grant) begin
        src_q  <= g_src;
        we_q   <= g_we;
        va     <= g_addr;
        vd_out <= g_wdata;
      end
      if (g_dma || !dma_req)
        starve <= 4'd0;
      else if (g_cpu && starve < SMAX)
        starve <= starve + 4'd1;
    end
  end

  // Pin values for the cycle we are entering.
  always_comb begin
    o_n_vrd   = !(nxt_state == STROBE && !nxt_we);
    o_n_vwr   = !(nxt_state == STROBE && nxt_we);
    o_vd_oe   = nxt_we && (nxt_state != IDLE);
    o_scr_ack = (nxt_state == RECOVER) && (nxt_src == SRC_SCR);
    o_cpu_ack = (nxt_state == RECOVER) && (nxt_src == SRC_CPU);
    o_dma_ack = (nxt_state == RECOVER) && (nxt_src == SRC_DMA);
    cap       = (state == STROBE) && (cnt == LAST) && !we_q;
  end

  // Registered strobes, acks and per-source read data.
  always_ff @(posedge clk28) begin
    if (rst) begin
      n_vrd     <= 1'b1;
      n_vwr     <= 1'b1;
      vd_oe     <= 1'b0;
      scr_ack   <= 1'b0;
      cpu_ack   <= 1'b0;
      dma_ack   <= 1'b0;
      scr_rdata <= 8'h00;
      cpu_rdata <= 8'h00;
      dma_rdata <= 8'h00;
    end else begin
      n_vrd   <= o_n_vrd;
      n_vwr   <= o_n_vwr;
      vd_oe   <= o_vd_oe;
      scr_ack <= o_scr_ack;
      cpu_ack <= o_cpu_ack;
      dma_ack <= o_dma_ack;
      if (cap) begin
        unique case (src_q)
          SRC_SCR: scr_rdata <= vd_in;
          SRC_CPU: cpu_rdata <= vd_in;
          SRC_DMA: dma_rdata <= vd_in;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sram_sequencer.sv
// tb_sram_sequencer: directed stimulus, timeline model of each access,
// per-cycle compare against the model plus hand-computed literal checks.
module tb_sram_sequencer;

  localparam int S = 3;
  localparam int D = 8;

  logic        clk28 = 1'b0;
  logic        rst;
  logic        scr_req;
  logic [18:0] scr_addr;
  logic        scr_ack;
  logic [7:0]  scr_rdata;
  logic        cpu_req, cpu_we;
  logic [18:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic        dma_req, dma_we;
  logic [18:0] dma_addr;
  logic [7:0]  dma_wdata;
  logic        dma_ack;
  logic [7:0]  dma_rdata;
  logic [18:0] va;
  logic [7:0]  vd_in, vd_out;
  logic        vd_oe, n_vrd, n_vwr, busy;

  int n_total = 0;
  int n_pass  = 0;
  logic mon_on = 1'b0;

  always #18 clk28 = ~clk28;

  sram_sequencer #(.STROBE_CYCLES(S), .DMA_STARVE(D)) dut (
    .clk28(clk28), .rst(rst),
    .scr_req(scr_req), .scr_addr(scr_addr),
    .scr_ack(scr_ack), .scr_rdata(scr_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .va(va), .vd_in(vd_in), .vd_out(vd_out),
    .vd_oe(vd_oe), .n_vrd(n_vrd), .n_vwr(n_vwr),
    .busy(busy)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t",
                  nm, act, exp, $time);
  endtask

  task automatic tick;
    @(posedge clk28);
    #1;
  endtask

  // Model: an access is a timeline, offset 1 = setup,
  // 2..S+1 = strobe, S+2 = ack cycle.
  logic        m_busy = 1'b0;
  int          m_t = 0;
  int          m_src = 0;
  logic        m_we = 1'b0;
  logic [18:0] m_addr = '0;
  logic [7:0]  m_wd = '0;
  int          m_starve = 0;
  logic [7:0]  m_rd [3];
  logic        m_ackc, m_arb, ms_ok, mc_ok, md_ok;
  int          m_win;

  always_comb begin
    m_ackc = m_busy && (m_t == S + 2);
    m_arb  = !m_busy || m_ackc;
    ms_ok  = scr_req && !(m_ackc && m_src == 0);
    mc_ok  = cpu_req && !(m_ackc && m_src == 1);
    md_ok  = dma_req && !(m_ackc && m_src == 2);
    m_win  = -1;
    if (m_arb) begin
      if (ms_ok) m_win = 0;
      else if (md_ok && (m_starve == D || !mc_ok)) m_win = 2;
      else if (mc_ok) m_win = 1;
    end
  end

  always @(posedge clk28) begin
    if (rst) begin
      m_busy   <= 1'b0;
      m_t      <= 0;
      m_starve <= 0;
      m_rd[0]  <= 8'h00;
      m_rd[1]  <= 8'h00;
      m_rd[2]  <= 8'h00;
    end else begin
      if (m_busy && m_t == S + 1 && !m_we) m_rd[m_src] <= vd_in;
      if (m_win >= 0) begin
        m_busy <= 1'b1;
        m_t    <= 1;
        m_src  <= m_win;
        m_we   <= (m_win == 1) ? cpu_we : (m_win == 2) ? dma_we : 1'b0;
        m_addr <= (m_win == 1) ? cpu_addr :
                  (m_win == 2) ? dma_addr : scr_addr;
        m_wd   <= (m_win == 1) ? cpu_wdata :
                  (m_win == 2) ? dma_wdata : 8'h00;
      end else if (m_busy) begin
        if (m_ackc) m_busy <= 1'b0;
        else m_t <= m_t + 1;
      end
      if (m_win == 2 || !dma_req) m_starve <= 0;
      else if (m_win == 1 && m_starve < D) m_starve <= m_starve + 1;
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk28) begin
    if (mon_on) begin
      automatic logic stb = m_busy && m_t >= 2 && m_t <= S + 1;
      chk("busy", busy, m_busy);
      chk("n_vrd", n_vrd, !(stb && !m_we));
      chk("n_vwr", n_vwr, !(stb && m_we));
      chk("vd_oe", vd_oe, m_busy && m_we);
      chk("scr_ack", scr_ack, m_ackc && m_src == 0);
      chk("cpu_ack", cpu_ack, m_ackc && m_src == 1);
      chk("dma_ack", dma_ack, m_ackc && m_src == 2);
      chk("scr_rdata", scr_rdata, m_rd[0]);
      chk("cpu_rdata", cpu_rdata, m_rd[1]);
      chk("dma_rdata", dma_rdata, m_rd[2]);
      chk("strobe_excl", !n_vrd && !n_vwr, 0);
      chk("oe_vs_rd", vd_oe && !n_vrd, 0);
      if (m_busy) chk("va", va, m_addr);
      if (m_busy && m_we) chk("vd_out", vd_out, m_wd);
    end
  end

  initial begin
    int ncpu, ndma, cpu_first;
    rst = 1'b1;
    scr_req = 0; scr_addr = '0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    vd_in = 8'h00;
    tick;
    mon_on = 1'b1;
    tick;
    tick;
    chk("rst_va", va, 0);
    chk("rst_nvrd", n_vrd, 1);
    chk("rst_nvwr", n_vwr, 1);
    chk("rst_oe", vd_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_vd_out", vd_out, 0);
    rst = 1'b0;
    tick;

    // CPU read
    vd_in = 8'hA5; cpu_we = 0; cpu_addr = 19'h7C123; cpu_req = 1;
    for (int k = 1; k <= 6; k++) begin
      tick;
      if (k == 1) chk("t1_va", va, 19'h7C123);
      if (k >= 2 && k <= 4) chk("t1_nvrd_low", n_vrd, 0);
      if (k == 5) begin
        chk("t1_ack", cpu_ack, 1);
        chk("t1_rdata", cpu_rdata, 8'hA5);
        cpu_req = 0;
      end
      if (k == 6) chk("t1_idle", busy, 0);
    end

    // CPU write
    cpu_we = 1; cpu_addr = 19'h40000; cpu_wdata = 8'h3F; cpu_req = 1;
    for (int k = 1; k <= 6; k++) begin
      tick;
      chk("t2_nvrd_high", n_vrd, 1);
      if (k <= 5) chk("t2_oe", vd_oe, 1);
      if (k >= 2 && k <= 4) chk("t2_nvwr_low", n_vwr, 0);
      if (k == 3) chk("t2_vd_out", vd_out, 8'h3F);
      if (k == 5) begin
        chk("t2_nvwr_high", n_vwr, 1);
        chk("t2_ack", cpu_ack, 1);
        cpu_req = 0;
      end
      if (k == 6) chk("t2_oe_off", vd_oe, 0);
    end

    // Screen and CPU together: back-to-back
    vd_in = 8'h77; scr_addr = 19'h12345; scr_req = 1;
    cpu_we = 0; cpu_addr = 19'h00100; cpu_req = 1;
    for (int k = 1; k <= 11; k++) begin
      tick;
      if (k == 5) begin
        chk("t3_scr_ack", scr_ack, 1);
        chk("t3_scr_rdata", scr_rdata, 8'h77);
        chk("t3_cpu_wait", cpu_ack, 0);
        scr_req = 0;
        vd_in = 8'h88;
      end
      if (k == 6) begin
        chk("t3_no_gap", busy, 1);
        chk("t3_va_cpu", va, 19'h00100);
      end
      if (k == 10) begin
        chk("t3_cpu_ack", cpu_ack, 1);
        chk("t3_cpu_rdata", cpu_rdata, 8'h88);
        cpu_req = 0;
      end
    end

    // Starvation: screen and CPU alternate, DMA forced in every 9th CPU slot
    vd_in = 8'h11; scr_req = 1; cpu_req = 1; cpu_we = 0;
    dma_req = 1; dma_we = 0; dma_addr = 19'h0ABCD;
    ncpu = 0; ndma = 0; cpu_first = 0;
    for (int k = 1; k <= 185; k++) begin
      tick;
      if (cpu_ack) ncpu++;
      if (dma_ack) begin
        if (ndma == 0) begin
          chk("starve_first", ncpu, D);
          cpu_first = ncpu;
        end else begin
          chk("starve_again", ncpu - cpu_first, D);
        end
        ndma++;
      end
    end
    chk("dma_grants", ndma, 2);
    scr_req = 0; cpu_req = 0; dma_req = 0;
    tick; tick;

    // Reset during write strobe
    cpu_we = 1; cpu_addr = 19'h01234; cpu_wdata = 8'h55; cpu_req = 1;
    tick; tick; tick;
    chk("t5_in_strobe", n_vwr, 0);
    rst = 1; cpu_req = 0;
    tick;
    chk("t5_nvwr", n_vwr, 1);
    chk("t5_oe", vd_oe, 0);
    chk("t5_busy", busy, 0);
    chk("t5_noack", cpu_ack, 0);
    rst = 0;
    tick;
    vd_in = 8'h5A; cpu_we = 0; cpu_addr = 19'h2AAAA; cpu_req = 1;
    for (int k = 1; k <= 5; k++) begin
      tick;
      if (k == 4) chk("t5_early", cpu_ack, 0);
      if (k == 5) begin
        chk("t5_ack", cpu_ack, 1);
        chk("t5_rdata", cpu_rdata, 8'h5A);
        cpu_req = 0;
      end
    end
    tick;

    // Request dropped mid-access
    vd_in = 8'hC3; cpu_we = 0; cpu_addr = 19'h00FFF; cpu_req = 1;
    for (int k = 1; k <= 7; k++) begin
      tick;
      if (k == 2) cpu_req = 0;
      if (k == 5) begin
        chk("t6_ack", cpu_ack, 1);
        chk("t6_rdata", cpu_rdata, 8'hC3);
      end
      if (k >= 6) chk("t6_no_regrant", busy, 0);
    end

    // DMA write then read
    dma_we = 1; dma_addr = 19'h7FFFF; dma_wdata = 8'h99; dma_req = 1;
    for (int k = 1; k <= 5; k++) begin
      tick;
      if (k == 3) chk("t7_vd_out", vd_out, 8'h99);
      if (k == 5) begin
        chk("t7_wack", dma_ack, 1);
        dma_req = 0;
      end
    end
    tick;
    vd_in = 8'h3C; dma_we = 0; dma_addr = 19'h00042; dma_req = 1;
    for (int k = 1; k <= 5; k++) begin
      tick;
      if (k == 1) chk("t7_va", va, 19'h00042);
      if (k == 5) begin
        chk("t7_rack", dma_ack, 1);
        chk("t7_rdata", dma_rdata, 8'h3C);
        dma_req = 0;
      end
    end
    tick; tick;

    mon_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
